// File: rtl/serv_mem_responder.sv
// Single-ported word memory answering the serv ibus and dbus Wishbone masters.
// dbus has fixed priority over ibus; each access takes WAIT_STATES idle cycles plus a one-cycle ack.
module serv_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1   // legal range 0..7
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_reg;
  logic [2:0]  cnt_reg;
  logic        dbus_gnt_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  logic [3:0]  sel_reg;
  logic        we_reg;

  logic        grant_any;
  logic        acc_fire;
  logic        acc_dbus;
  logic [31:0] acc_adr;
  logic [31:0] acc_dat;
  logic [3:0]  acc_sel;
  logic        acc_we;
  logic [DEPTH_LOG2-1:0] acc_word;
  logic        acc_oor;
  logic        wr_en;
  logic [31:0] rd_word;
  logic        unused_adr_bits;

  assign grant_any = i_dbus_cyc | i_ibus_cyc;

  // The access happens on the edge that enters ACK. With zero wait states that is
  // the grant edge itself, so the transaction is taken straight from the ports.
  always_comb begin
    acc_fire = 1'b0;
    acc_dbus = dbus_gnt_reg;
    acc_adr  = adr_reg;
    acc_dat  = dat_reg;
    acc_sel  = sel_reg;
    acc_we   = we_reg;
    if (state_reg == IDLE && WAIT_STATES == 0 && grant_any) begin
      acc_fire = 1'b1;
      acc_dbus = i_dbus_cyc;
      acc_adr  = i_dbus_cyc ? i_dbus_adr : i_ibus_adr;
      acc_dat  = i_dbus_dat;
      acc_sel  = i_dbus_sel;
      acc_we   = i_dbus_cyc & i_dbus_we;
    end else if (state_reg == WAIT && cnt_reg == 3'd0) begin
      acc_fire = 1'b1;
    end
    // The memory has no reset, so an abandoned transaction must not write.
    acc_fire = acc_fire && !i_rst;
  end

  assign acc_word        = acc_adr[DEPTH_LOG2+1:2];
  assign acc_oor         = |acc_adr[31:DEPTH_LOG2+2];
  assign wr_en           = acc_fire & acc_we & ~acc_oor;
  assign unused_adr_bits = ^acc_adr[1:0];

  // One byte-wide array per lane gives byte-enable writes without read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && acc_sel[gi]) begin
        mem[acc_word] <= acc_dat[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = mem[acc_word];
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      dbus_gnt_reg <= 1'b0;
      adr_reg      <= 32'd0;
      dat_reg      <= 32'd0;
      sel_reg      <= 4'd0;
      we_reg       <= 1'b0;
      o_ibus_ack   <= 1'b0;
      o_dbus_ack   <= 1'b0;
      o_ibus_rdt   <= 32'd0;
      o_dbus_rdt   <= 32'd0;
      o_err        <= 1'b0;
    end else begin
      o_ibus_ack <= 1'b0;
      o_dbus_ack <= 1'b0;

      if (acc_fire) begin
        if (acc_dbus) begin
          o_dbus_ack <= 1'b1;
          if (!acc_we) begin
            o_dbus_rdt <= acc_oor ? 32'd0 : rd_word;
          end
        end else begin
          o_ibus_ack <= 1'b1;
          o_ibus_rdt <= acc_oor ? 32'd0 : rd_word;
        end
        if (acc_oor) begin
          o_err <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            dbus_gnt_reg <= i_dbus_cyc;
            adr_reg      <= i_dbus_cyc ? i_dbus_adr : i_ibus_adr;
            dat_reg      <= i_dbus_dat;
            sel_reg      <= i_dbus_sel;
            we_reg       <= i_dbus_cyc & i_dbus_we;
            cnt_reg      <= CNT_INIT;
            state_reg    <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 3'd0) begin
            state_reg <= ACK;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_mem_responder.sv
// Scoreboard bench for serv_mem_responder: drivers push expected acks, a monitor pops and compares.
module tb_serv_mem_responder;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        o_err;

  serv_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          exp_cyc;
    bit          chk_rdt;
    logic [31:0] rdt;
    int          id;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int checks    = 0;
  int failures  = 0;
  int txn_id    = 0;
  int dbus_acks = 0;
  int ibus_acks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (o_ibus_ack || o_dbus_ack) begin
      check32("ack_exclusive", 32'(o_ibus_ack & o_dbus_ack), 32'd0);
    end
    if (o_dbus_ack) begin
      dbus_acks++;
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dbus_ack actual=1 required=0 cyc=%0d", cyc_cnt);
      end else begin
        e = dq.pop_front();
        $display("dbus txn%0d ack cyc=%0d rdt=%h", e.id, cyc_cnt, o_dbus_rdt);
        check32($sformatf("dbus_latency_txn%0d", e.id), 32'(cyc_cnt), 32'(e.exp_cyc));
        if (e.chk_rdt) check32($sformatf("dbus_rdt_txn%0d", e.id), o_dbus_rdt, e.rdt);
      end
    end
    if (o_ibus_ack) begin
      ibus_acks++;
      if (iq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ibus_ack actual=1 required=0 cyc=%0d", cyc_cnt);
      end else begin
        e = iq.pop_front();
        $display("ibus txn%0d ack cyc=%0d rdt=%h", e.id, cyc_cnt, o_ibus_rdt);
        check32($sformatf("ibus_latency_txn%0d", e.id), 32'(cyc_cnt), 32'(e.exp_cyc));
        check32($sformatf("ibus_rdt_txn%0d", e.id), o_ibus_rdt, e.rdt);
      end
    end
  endtask

  // Called on a falling edge; lat = falling edges from issue until the ack is visible.
  task automatic dbus_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input logic [31:0] exp_rdt, input int lat);
    exp_t e;
    bit   got = 1'b0;
    e.exp_cyc = cyc_cnt + lat;
    e.chk_rdt = !we;
    e.rdt     = exp_rdt;
    e.id      = txn_id;
    txn_id++;
    dq.push_back(e);
    i_dbus_adr = adr;
    i_dbus_dat = dat;
    i_dbus_sel = sel;
    i_dbus_we  = we;
    i_dbus_cyc = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = o_dbus_ack;
    end
    i_dbus_cyc = 1'b0;
    check32($sformatf("dbus_acked_txn%0d", e.id), 32'(got), 32'd1);
    @(negedge clk);
  endtask

  task automatic ibus_xfer(input logic [31:0] adr, input logic [31:0] exp_rdt, input int lat);
    exp_t e;
    bit   got = 1'b0;
    e.exp_cyc = cyc_cnt + lat;
    e.chk_rdt = 1'b1;
    e.rdt     = exp_rdt;
    e.id      = txn_id;
    txn_id++;
    iq.push_back(e);
    i_ibus_adr = adr;
    i_ibus_cyc = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = o_ibus_ack;
    end
    i_ibus_cyc = 1'b0;
    check32($sformatf("ibus_acked_txn%0d", e.id), 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b1;
    i_ibus_adr = 32'd0;
    i_ibus_cyc = 1'b0;
    i_dbus_adr = 32'd0;
    i_dbus_dat = 32'd0;
    i_dbus_sel = 4'd0;
    i_dbus_we  = 1'b0;
    i_dbus_cyc = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin
        int acks_before;
        repeat (2) @(negedge clk);
        check32("reset_ibus_ack", 32'(o_ibus_ack), 32'd0);
        check32("reset_dbus_ack", 32'(o_dbus_ack), 32'd0);
        check32("reset_ibus_rdt", o_ibus_rdt, 32'd0);
        check32("reset_dbus_rdt", o_dbus_rdt, 32'd0);
        check32("reset_err", 32'(o_err), 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // full-word write, fetch it back, partial-lane update, empty-lane write
        dbus_xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 2);
        ibus_xfer(32'h10, 32'hDEADBEEF, 2);
        dbus_xfer(32'h20, 32'h12345678, 4'hF, 1'b1, 32'h0, 2);
        dbus_xfer(32'h10, 32'h0000AB00, 4'b0010, 1'b1, 32'h0, 2);
        dbus_xfer(32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADABEF, 2);
        dbus_xfer(32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, 2);
        ibus_xfer(32'h13, 32'hDEADABEF, 2);

        // simultaneous requests: dbus first, ibus three cycles later
        fork
          dbus_xfer(32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678, 2);
          ibus_xfer(32'h10, 32'hDEADABEF, 5);
        join
        check32("err_before_oor", 32'(o_err), 32'd0);

        // out-of-range write must not alias onto word 0
        dbus_xfer(32'h0, 32'hA5A50F0F, 4'hF, 1'b1, 32'h0, 2);
        dbus_xfer(32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 2);
        check32("err_after_oor", 32'(o_err), 32'd1);
        dbus_xfer(32'h1000, 32'h0, 4'h0, 1'b0, 32'h0, 2);
        ibus_xfer(32'h1000, 32'h0, 2);
        dbus_xfer(32'h0, 32'h0, 4'h0, 1'b0, 32'hA5A50F0F, 2);
        ibus_xfer(32'h20, 32'h12345678, 2);
        check32("err_sticky", 32'(o_err), 32'd1);

        // reset pulse in the WAIT cycle of a write to 0x20
        i_dbus_adr = 32'h20;
        i_dbus_dat = 32'hCAFEF00D;
        i_dbus_sel = 4'hF;
        i_dbus_we  = 1'b1;
        i_dbus_cyc = 1'b1;
        @(posedge clk);
        #2;
        i_rst      = 1'b1;
        i_dbus_cyc = 1'b0;
        #1;
        check32("midrun_rst_ibus_ack", 32'(o_ibus_ack), 32'd0);
        check32("midrun_rst_dbus_ack", 32'(o_dbus_ack), 32'd0);
        check32("midrun_rst_err", 32'(o_err), 32'd0);
        check32("midrun_rst_ibus_rdt", o_ibus_rdt, 32'd0);
        check32("midrun_rst_dbus_rdt", o_dbus_rdt, 32'd0);
        #1;
        i_rst = 1'b0;
        acks_before = dbus_acks;
        repeat (6) @(negedge clk);
        check32("abandoned_no_ack", 32'(dbus_acks), 32'(acks_before));
        dbus_xfer(32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678, 2);
        check32("err_after_rst", 32'(o_err), 32'd0);

        check32("dbus_queue_drained", 32'(dq.size()), 32'd0);
        check32("ibus_queue_drained", 32'(iq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join
  end

endmodule
